// File: rtl/ro_freq_meas_ctrl_if.sv
// Bus between the ring-oscillator measurement sequencer and its user.
// The master drives the request side (start, abort, ro_sel, win_len, scan)
// and the divided oscillator outputs (ro_in). The slave (the sequencer)
// drives ro_en and the result side.
interface ro_freq_meas_ctrl_if #(
  parameter int NUM_RO = 4,
  parameter int SEL_W  = 2,
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 16
);
  // Handshake: start is a single-cycle request with no ready. It is accepted
  // only on a cycle where busy is low and abort is low; a start seen while
  // busy is dropped, not queued. ro_sel, win_len and scan are sampled on the
  // accepting cycle only. done is a one-cycle strobe; result, result_id and
  // overflow are valid from that cycle until the next done.
  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  ro_sel;
  logic [WIN_W-1:0]  win_len;
  logic              scan;
  logic [NUM_RO-1:0] ro_in;
  logic [NUM_RO-1:0] ro_en;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  result;
  logic [SEL_W-1:0]  result_id;
  logic              overflow;

  modport master (
    output start, abort, ro_sel, win_len, scan, ro_in,
    input  ro_en, busy, done, result, result_id, overflow
  );

  modport slave (
    input  start, abort, ro_sel, win_len, scan, ro_in,
    output ro_en, busy, done, result, result_id, overflow
  );
endinterface

// File: rtl/ro_freq_meas_ctrl.sv
// Ring-oscillator bank sequencer: picks one oscillator, enables it, waits
// SETTLE_CYC cycles, then counts synchronized rising edges of its divided
// output over a window of clk cycles and latches the count.
// Optional build macro RO_AUTOSCAN_EN: when defined, a start with scan=1
// walks from ro_sel up to NUM_RO-1, one measurement per oscillator.
module ro_freq_meas_ctrl #(
  parameter int NUM_RO     = 4,
  parameter int SEL_W      = 2,
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  ro_freq_meas_ctrl_if.slave  bus,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > ST_W) ? WIN_W : ST_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [SEL_W-1:0] SEL_MAX     = SEL_W'(NUM_RO - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              scan_q, scan_d;
  logic [NUM_RO-1:0] ro_en_q, ro_en_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  result_q, result_d;
  logic [SEL_W-1:0]  result_id_q, result_id_d;
  logic              overflow_q, overflow_d;

  logic [NUM_RO-1:0] sync1_q, sync2_q, prev_q;
  logic              edge_det;
  logic [CNT_W-1:0]  cnt_acc;
  logic              ovf_acc;
  logic              scan_req;
  logic [SEL_W-1:0]  sel_clamped;
  logic [WIN_W-1:0]  win_clamped;

`ifdef RO_AUTOSCAN_EN
  assign scan_req = bus.scan;
`else
  logic unused_scan;
  assign unused_scan = bus.scan;
  assign scan_req    = 1'b0;
`endif

  // Request sanitising: out-of-range select clamps to the last oscillator,
  // a zero window is stretched to one cycle.
  assign sel_clamped = (bus.ro_sel > SEL_MAX) ? SEL_MAX : bus.ro_sel;
  assign win_clamped = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;

  // Per-bit edge detection runs continuously so switching oscillators never
  // sees a stale previous value.
  assign edge_det = sync2_q[sel_q] & ~prev_q[sel_q];

  // Two-flop synchronizers plus previous-value register for all ro_in bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.ro_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Saturating count including this cycle's edge; overflow marks an edge lost
  // to saturation.
  always_comb begin
    cnt_acc = cnt_q;
    ovf_acc = ovf_q;
    if (edge_det) begin
      if (cnt_q == CNT_MAX) ovf_acc = 1'b1;
      else                  cnt_acc = cnt_q + CNT_W'(1);
    end
  end

  // Next-state and next-output logic for the measurement sequence.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    win_d       = win_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    scan_d      = scan_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_id_d = result_id_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          sel_d   = sel_clamped;
          win_d   = win_clamped;
          scan_d  = scan_req;
          tmr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = S_MEASURE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_MEASURE: begin
        cnt_d = cnt_acc;
        ovf_d = ovf_acc;
        if (tmr_q == TMR_W'(win_q - WIN_W'(1))) begin
          result_d    = cnt_acc;
          result_id_d = sel_q;
          overflow_d  = ovf_acc;
          done_d      = 1'b1;
          tmr_d       = '0;
          if (scan_q && (sel_q != SEL_MAX)) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = S_GAP;
          end else begin
            scan_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_GAP: begin
        // One cycle with every oscillator off before the next one settles.
        cnt_d   = '0;
        ovf_d   = 1'b0;
        tmr_d   = '0;
        state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort cancels any activity without touching the published result.
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d     = S_IDLE;
      scan_d      = 1'b0;
      done_d      = 1'b0;
      result_d    = result_q;
      result_id_d = result_id_q;
      overflow_d  = overflow_q;
    end

    ro_en_d = '0;
    if ((state_d == S_SETTLE) || (state_d == S_MEASURE)) begin
      ro_en_d = NUM_RO'(1) << sel_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      win_q       <= '0;
      tmr_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      scan_q      <= 1'b0;
      ro_en_q     <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      win_q       <= win_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      scan_q      <= scan_d;
      ro_en_q     <= ro_en_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.ro_en     = ro_en_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.result_id = result_id_q;
  assign bus.overflow  = overflow_q;
  assign state_o       = state_q;

endmodule
